u_mem_arbiter: RTL and testbench
================================

Name: u_mem_arbiter

Overview:
Two-port Avalon-MM arbiter that shares one local-memory port (u_mem) between the DMA engine (port 0) and the kernel datapath (port 1).
- Round-robin command arbitration with write-burst locking.
- Read-response routing through an in-order tag FIFO.
- Outstanding-read throttling.
- Sits between both masters and the single local_mem FIU port.

Parameters:
ADDR_WIDTH, 32, word (64 B line) address width.
DATA_WIDTH, 512, data bus width; byteenable is DATA_WIDTH/8.
BURST_WIDTH, 7, burstcount width; legal burstcount 1..2^(BURST_WIDTH-1).
MAX_OUTSTANDING, 64, maximum read beats in flight; power of two, >= max burst.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
sN_address  in  ADDR_WIDTH  requester N address (N = 0 DMA, 1 kernel)
sN_burstcount  in  BURST_WIDTH  requester N burst length
sN_writedata  in  DATA_WIDTH  requester N write data
sN_byteenable  in  DATA_WIDTH/8  requester N byte enables
sN_read  in  1  requester N read command
sN_write  in  1  requester N write beat
sN_waitrequest  out  1  stall to requester N
sN_readdata  out  DATA_WIDTH  read data (broadcast of m_readdata)
sN_readdatavalid  out  1  read beat valid for requester N
m_address  out  ADDR_WIDTH  to local_mem
m_burstcount  out  BURST_WIDTH  to local_mem
m_writedata  out  DATA_WIDTH  to local_mem
m_byteenable  out  DATA_WIDTH/8  to local_mem
m_read  out  1  to local_mem
m_write  out  1  to local_mem
m_waitrequest  in  1  from local_mem
m_readdata  in  DATA_WIDTH  from local_mem
m_readdatavalid  in  1  from local_mem
outstanding  out  $clog2(MAX_OUTSTANDING)+1  read beats in flight
err  out  1  sticky protocol error

Behaviour:
Reset: the reset values below are the state immediately after reset deasserts.
- m_read = m_write = 0.
- s0_waitrequest = s1_waitrequest = 1 while reset is high.
- sN_readdatavalid = 0.
- outstanding = 0, err = 0.
- Tag FIFO empty, lock cleared, RR pointer prefers port 0.

Request and grant:
- reqN = sN_read | sN_write.
- The grant is combinational from reqN, the RR pointer and the lock.
- If only one port requests, it is granted.
- If both request, the port the pointer prefers is granted.

Forwarding:
- The granted port's address, burstcount, writedata, byteenable, read and write drive m_* combinationally.
- With no grant, m_read = m_write = 0 and the other m_* fields are don't-care.
- Zero added command latency.

Waitrequest:
- Ungranted port: sN_waitrequest = 1.
- Granted port: sN_waitrequest = m_waitrequest | throttle.
- throttle = sN_read & (outstanding + sN_burstcount > MAX_OUTSTANDING).
- While throttled, m_read is forced to 0.

Accept and RR update:
- accept = (m_read | m_write) & ~m_waitrequest.
- A command counts as complete when a read is accepted, or when the last beat of a write burst is accepted.
- On completion, the pointer prefers the other port.

Write-burst lock:
- When the first beat of a write with burstcount > 1 is accepted, the block locks to that port and loads a beat counter with burstcount-1.
- Each further accepted write beat decrements the counter; the lock releases when the last beat is accepted.
- While locked, the other port stays stalled even if it requests.
- The locked port's read input is ignored until release.

Tag FIFO and read routing:
- On each accepted read, {port id, burstcount} is pushed into a tag FIFO of depth MAX_OUTSTANDING, and outstanding += burstcount.
- On each m_readdatavalid:
  - Route to the head entry's port: sN_readdatavalid = m_readdatavalid & (head id == N).
  - Decrement the head's remaining-beat counter; pop the entry after its last beat.
  - outstanding -= 1.
- Same-cycle push and response: the net outstanding update is +burstcount-1. A push into an empty FIFO does not affect the response in that same cycle.

Error conditions (set err, sticky until reset):
- m_readdatavalid with the FIFO empty: the beat is dropped.
- sN_read and sN_write both high on the granted port: forwarded as a write only.
- burstcount = 0 on an accepted command: treated as 1.

Reset mid-operation:
- All state clears immediately: lock, FIFO, counters.
- In-flight responses arriving after reset hit an empty FIFO and set err. Software must quiesce before reset.

Test Plan:
1. Only s0 issues 8 single-beat writes to addr 0x10..0x17, m_waitrequest = 0 → 8 consecutive m_write cycles; s1_waitrequest = 1 throughout; outstanding = 0.
2. s0 and s1 both hold single reads continuously for 10 cycles → m_read alternates port 0,1,0,1…; responses with 3-cycle latency raise s0/s1_readdatavalid in the same alternating order.
3. s1 starts a write burst of 4 while s0 requests at beat 2 → beats 2–4 from s1 forwarded; s0 granted only in the cycle after s1's 4th beat; with m_waitrequest = 1 on beat 3, the lock holds.
4. MAX_OUTSTANDING = 64, s1 issues 8 reads of burst 8 with no responses returned → 8 accepted, outstanding = 64; a 9th read stalls; one returned beat still stalls (63+8 > 64); 8 returned beats allow acceptance.
5. m_readdatavalid pulsed with no reads outstanding → err = 1 next cycle and stays 1; both sN_readdatavalid = 0; reset clears err.
6. Reset asserted mid write burst (after 2 of 4 beats) → m_write = 0 during reset, lock cleared; s0 granted first afterwards when both request.

Source files
------------

// File: rtl/u_mem_arbiter.sv
// Two-port Avalon-MM arbiter sharing one local-memory port between the DMA engine (port 0)
// and the kernel datapath (port 1): round-robin grant, write-burst lock, in-order read routing.
module u_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_WIDTH     = 7,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ADDR_WIDTH-1:0]              s0_address,
  input  logic [BURST_WIDTH-1:0]             s0_burstcount,
  input  logic [DATA_WIDTH-1:0]              s0_writedata,
  input  logic [DATA_WIDTH/8-1:0]            s0_byteenable,
  input  logic                               s0_read,
  input  logic                               s0_write,
  output logic                               s0_waitrequest,
  output logic [DATA_WIDTH-1:0]              s0_readdata,
  output logic                               s0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]              s1_address,
  input  logic [BURST_WIDTH-1:0]             s1_burstcount,
  input  logic [DATA_WIDTH-1:0]              s1_writedata,
  input  logic [DATA_WIDTH/8-1:0]            s1_byteenable,
  input  logic                               s1_read,
  input  logic                               s1_write,
  output logic                               s1_waitrequest,
  output logic [DATA_WIDTH-1:0]              s1_readdata,
  output logic                               s1_readdatavalid,
  output logic [ADDR_WIDTH-1:0]              m_address,
  output logic [BURST_WIDTH-1:0]             m_burstcount,
  output logic [DATA_WIDTH-1:0]              m_writedata,
  output logic [DATA_WIDTH/8-1:0]            m_byteenable,
  output logic                               m_read,
  output logic                               m_write,
  input  logic                               m_waitrequest,
  input  logic [DATA_WIDTH-1:0]              m_readdata,
  input  logic                               m_readdatavalid,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int SW = ((OW > BURST_WIDTH) ? OW : BURST_WIDTH) + 1;
  localparam logic [BURST_WIDTH-1:0] BC_ONE  = BURST_WIDTH'(1);
  localparam logic [PW-1:0]          PTR_ONE = PW'(1);
  localparam logic [OW-1:0]          OUT_ONE = OW'(1);

  // Handshake: a command transfers on a cycle where m_read|m_write is high and
  // m_waitrequest is low; the granted requester sees the same condition as its own
  // waitrequest low, every other requester is held with waitrequest high.

  logic                   lock_q, lock_d;
  logic                   lock_id_q, lock_id_d;
  logic [BURST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                   rr_q, rr_d;
  logic                   err_q, err_d;
  logic [OW-1:0]          out_q, out_d;
  logic [OW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [BURST_WIDTH-1:0] head_beat_q, head_beat_d;

  logic [MAX_OUTSTANDING-1:0] tag_id_q;
  logic [BURST_WIDTH-1:0]     tag_bc_q [MAX_OUTSTANDING];

  logic                   req0, req1;
  logic                   gnt_valid, gnt_id;
  logic                   g_read, g_write;
  logic [BURST_WIDTH-1:0] g_bc, bc_eff;
  logic                   rd_eff, wr_eff;
  logic [SW-1:0]          rd_sum;
  logic                   throttle;
  logic                   accept, push, rsp_ok, pop;
  logic                   head_id;
  logic [BURST_WIDTH-1:0] head_bc;

  assign req0 = s0_read | s0_write;
  assign req1 = s1_read | s1_write;

  // While locked only the burst owner may proceed, and only with write beats.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (!reset) begin
      if (lock_q) begin
        gnt_id    = lock_id_q;
        gnt_valid = lock_id_q ? s1_write : s0_write;
      end else if (req0 && req1) begin
        gnt_valid = 1'b1;
        gnt_id    = rr_q;
      end else if (req0) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (req1) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  assign g_read  = gnt_id ? s1_read : s0_read;
  assign g_write = gnt_id ? s1_write : s0_write;
  assign g_bc    = gnt_id ? s1_burstcount : s0_burstcount;
  assign bc_eff  = (g_bc == '0) ? BC_ONE : g_bc;

  // A read+write collision is forwarded as the write alone.
  assign wr_eff   = gnt_valid & g_write;
  assign rd_eff   = gnt_valid & g_read & ~g_write & ~lock_q;
  assign rd_sum   = SW'(out_q) + SW'(bc_eff);
  assign throttle = rd_eff & (rd_sum > SW'(MAX_OUTSTANDING));

  assign m_address    = gnt_id ? s1_address : s0_address;
  assign m_writedata  = gnt_id ? s1_writedata : s0_writedata;
  assign m_byteenable = gnt_id ? s1_byteenable : s0_byteenable;
  assign m_burstcount = bc_eff;
  assign m_read       = rd_eff & ~throttle;
  assign m_write      = wr_eff;

  assign s0_waitrequest = (gnt_valid && !gnt_id) ? (m_waitrequest | throttle) : 1'b1;
  assign s1_waitrequest = (gnt_valid &&  gnt_id) ? (m_waitrequest | throttle) : 1'b1;

  assign accept  = (m_read | m_write) & ~m_waitrequest;
  assign push    = accept & m_read;
  assign rsp_ok  = m_readdatavalid & (cnt_q != '0);
  assign head_id = tag_id_q[rd_ptr_q];
  assign head_bc = tag_bc_q[rd_ptr_q];
  assign pop     = rsp_ok & ((head_beat_q + BC_ONE) == head_bc);

  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s0_readdatavalid = rsp_ok & ~head_id;
  assign s1_readdatavalid = rsp_ok & head_id;

  always_comb begin
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    beat_cnt_d  = beat_cnt_q;
    rr_d        = rr_q;
    err_d       = err_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    head_beat_d = head_beat_q;

    if (accept && m_write) begin
      if (lock_q) begin
        if (beat_cnt_q <= BC_ONE) begin
          lock_d = 1'b0;
          rr_d   = ~lock_id_q;
        end else begin
          beat_cnt_d = beat_cnt_q - BC_ONE;
        end
      end else if (bc_eff > BC_ONE) begin
        lock_d     = 1'b1;
        lock_id_d  = gnt_id;
        beat_cnt_d = bc_eff - BC_ONE;
      end else begin
        rr_d = ~gnt_id;
      end
    end

    if (push) begin
      rr_d     = ~gnt_id;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      out_d    = out_d + OW'(bc_eff);
    end

    // The response side only looks at registered FIFO state, so a same-cycle
    // push into an empty FIFO cannot claim the beat.
    if (rsp_ok) begin
      out_d = out_d - OUT_ONE;
      if (pop) begin
        head_beat_d = '0;
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
      end else begin
        head_beat_d = head_beat_q + BC_ONE;
      end
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + OUT_ONE;
      2'b01:   cnt_d = cnt_q - OUT_ONE;
      default: cnt_d = cnt_q;
    endcase

    if ((m_readdatavalid && cnt_q == '0) ||
        (gnt_valid && g_read && g_write) ||
        (accept && g_bc == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q      <= 1'b0;
      lock_id_q   <= 1'b0;
      beat_cnt_q  <= '0;
      rr_q        <= 1'b0;
      err_q       <= 1'b0;
      out_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      head_beat_q <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      beat_cnt_q  <= beat_cnt_d;
      rr_q        <= rr_d;
      err_q       <= err_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      head_beat_q <= head_beat_d;
    end
  end

  // Tag storage needs no reset: entries are only read between valid pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_id_q[wr_ptr_q] <= gnt_id;
      tag_bc_q[wr_ptr_q] <= bc_eff;
    end
  end

  assign outstanding = out_q;
  assign err         = err_q;

endmodule

// File: tb/tb_u_mem_arbiter.sv
// Directed bench for u_mem_arbiter: command and read-response scoreboards fed by the
// stimulus, plus a simple local-memory responder with programmable beat budget.
module tb_u_mem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 512;
  localparam int BW    = 7;
  localparam int MO    = 64;
  localparam int OW    = $clog2(MO) + 1;
  localparam int LAT   = 3;
  localparam int CMD_W = 2 + 32 + BW + 32;
  localparam int RSP_W = 2 + 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   s0_address, s1_address;
  logic [BW-1:0]   s0_burstcount, s1_burstcount;
  logic [DW-1:0]   s0_writedata, s1_writedata;
  logic [DW/8-1:0] s0_byteenable, s1_byteenable;
  logic            s0_read, s0_write, s1_read, s1_write;
  logic            s0_waitrequest, s1_waitrequest;
  logic [DW-1:0]   s0_readdata, s1_readdata;
  logic            s0_readdatavalid, s1_readdatavalid;
  logic [AW-1:0]   m_address;
  logic [BW-1:0]   m_burstcount;
  logic [DW-1:0]   m_writedata;
  logic [DW/8-1:0] m_byteenable;
  logic            m_read, m_write;
  logic            m_waitrequest = 1'b0;
  logic [DW-1:0]   m_readdata = '0;
  logic            m_readdatavalid = 1'b0;
  logic [OW-1:0]   outstanding;
  logic            err;

  u_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset(reset),
    .s0_address(s0_address), .s0_burstcount(s0_burstcount), .s0_writedata(s0_writedata),
    .s0_byteenable(s0_byteenable), .s0_read(s0_read), .s0_write(s0_write),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_burstcount(s1_burstcount), .s1_writedata(s1_writedata),
    .s1_byteenable(s1_byteenable), .s1_read(s1_read), .s1_write(s1_write),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_read(m_read), .m_write(m_write),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .outstanding(outstanding), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [CMD_W-1:0] exp_cmd_q[$];
  logic [RSP_W-1:0] exp_rsp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk_cmd(input bit wr, input bit rd, input logic [31:0] a,
                                              input logic [BW-1:0] bc, input logic [31:0] d);
    return {wr, rd, a, bc, d};
  endfunction

  function automatic logic [RSP_W-1:0] mk_rsp(input int port, input logic [31:0] d);
    return {(port == 1), (port == 0), d};
  endfunction

  // ---------------- memory responder ----------------
  int cyc      = 0;
  int budget   = -1;
  int last_due = 0;
  logic [31:0] pend_data[$];
  int          pend_due[$];

  always @(negedge clk) begin
    if (!reset && m_read && !m_waitrequest) begin
      for (int b = 0; b < int'(m_burstcount); b++) begin
        int due;
        due = cyc + LAT;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_data.push_back(m_address + 32'(b));
        pend_due.push_back(due);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    cyc++;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
    if (pend_due.size() != 0 && pend_due[0] <= cyc && budget != 0) begin
      m_readdatavalid = 1'b1;
      m_readdata      = DW'(pend_data.pop_front());
      void'(pend_due.pop_front());
      if (budget > 0) budget--;
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!reset && (m_read || m_write) && !m_waitrequest) begin
      logic [CMD_W-1:0] got, want;
      got = mk_cmd(m_write, m_read, m_address, m_burstcount, m_writedata[31:0]);
      n_checks++;
      if (exp_cmd_q.size() == 0) begin
        n_fail++;
        $display("FAIL cmd_unexpected: got %0h required none", got);
      end else begin
        want = exp_cmd_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL cmd: got %0h required %0h", got, want);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (s0_readdatavalid || s1_readdatavalid) begin
      logic [RSP_W-1:0] got, want;
      got = {s1_readdatavalid, s0_readdatavalid,
             s1_readdatavalid ? s1_readdata[31:0] : s0_readdata[31:0]};
      n_checks++;
      if (exp_rsp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got %0h required none", got);
      end else begin
        want = exp_rsp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL rsp: got %0h required %0h", got, want);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_address = '0; s0_burstcount = '0; s0_writedata = '0; s0_byteenable = '0;
    s0_read = 1'b0;  s0_write = 1'b0;
    s1_address = '0; s1_burstcount = '0; s1_writedata = '0; s1_byteenable = '0;
    s1_read = 1'b0;  s1_write = 1'b0;
  endtask

  task automatic drive(input int p, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [BW-1:0] bc, input logic [31:0] d);
    if (p == 0) begin
      s0_read = rd; s0_write = wr; s0_address = a; s0_burstcount = bc;
      s0_writedata = DW'(d); s0_byteenable = '1;
    end else begin
      s1_read = rd; s1_write = wr; s1_address = a; s1_burstcount = bc;
      s1_writedata = DW'(d); s1_byteenable = '1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    m_waitrequest = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((pend_due.size() != 0 || exp_rsp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_drain_in_time"}, 128'(n < 300), 128'(1));
    @(negedge clk);
    check({name, "_outstanding_zero"}, 128'(outstanding), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    bit accepted;
    clear_inputs();
    drive(0, 1'b1, 1'b0, 32'h0, 7'd1, 32'h0);
    drive(1, 1'b0, 1'b1, 32'h0, 7'd1, 32'h0);
    @(negedge clk);
    check("rst_s0_wait", 128'(s0_waitrequest), 128'(1));
    check("rst_s1_wait", 128'(s1_waitrequest), 128'(1));
    check("rst_m_read", 128'(m_read), 128'(0));
    check("rst_m_write", 128'(m_write), 128'(0));
    tick();
    clear_inputs();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_outstanding", 128'(outstanding), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_rdv", 128'({s1_readdatavalid, s0_readdatavalid}), 128'(0));

    // Test 1: s0 alone, 8 single writes.
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h10 + 32'(i), 7'd1, 32'h1000 + 32'(i)));
      drive(0, 1'b0, 1'b1, 32'h10 + 32'(i), 7'd1, 32'h1000 + 32'(i));
      @(negedge clk);
      check("t1_s0_wait", 128'(s0_waitrequest), 128'(0));
      check("t1_s1_wait", 128'(s1_waitrequest), 128'(1));
      tick();
    end
    clear_inputs();
    @(negedge clk);
    check("t1_outstanding", 128'(outstanding), 128'(0));

    // Test 2: both hold single reads for 10 cycles, grants alternate from port 0.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      exp_cmd_q.push_back(mk_cmd(1'b0, 1'b1, (k % 2 == 1) ? 32'h200 : 32'h100, 7'd1, 32'h0));
      exp_rsp_q.push_back(mk_rsp(k % 2, (k % 2 == 1) ? 32'h200 : 32'h100));
    end
    drive(0, 1'b1, 1'b0, 32'h100, 7'd1, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h200, 7'd1, 32'h0);
    for (int k = 0; k < 10; k++) tick();
    clear_inputs();
    wait_drain("t2");

    // Test 3: s1 write burst of 4 locks out s0, stall on beat 3.
    do_reset();
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h300, 7'd4, 32'hA0));
    drive(1, 1'b0, 1'b1, 32'h300, 7'd4, 32'hA0);
    @(negedge clk);
    check("t3_b1_s1_wait", 128'(s1_waitrequest), 128'(0));
    tick();
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h300, 7'd4, 32'hA1));
    drive(1, 1'b0, 1'b1, 32'h300, 7'd4, 32'hA1);
    drive(0, 1'b0, 1'b1, 32'h40, 7'd1, 32'hB0);
    @(negedge clk);
    check("t3_b2_s0_wait", 128'(s0_waitrequest), 128'(1));
    check("t3_b2_s1_wait", 128'(s1_waitrequest), 128'(0));
    tick();
    drive(1, 1'b0, 1'b1, 32'h300, 7'd4, 32'hA2);
    m_waitrequest = 1'b1;
    @(negedge clk);
    check("t3_stall_s0_wait", 128'(s0_waitrequest), 128'(1));
    check("t3_stall_s1_wait", 128'(s1_waitrequest), 128'(1));
    check("t3_stall_wdata", 128'(m_writedata[31:0]), 128'(32'hA2));
    tick();
    m_waitrequest = 1'b0;
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h300, 7'd4, 32'hA2));
    @(negedge clk);
    check("t3_b3_s0_wait", 128'(s0_waitrequest), 128'(1));
    tick();
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h300, 7'd4, 32'hA3));
    drive(1, 1'b0, 1'b1, 32'h300, 7'd4, 32'hA3);
    @(negedge clk);
    check("t3_b4_s0_wait", 128'(s0_waitrequest), 128'(1));
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 7'd0, 32'h0);
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h40, 7'd1, 32'hB0));
    @(negedge clk);
    check("t3_after_s0_wait", 128'(s0_waitrequest), 128'(0));
    tick();
    clear_inputs();

    // Test 4: outstanding-read throttle with responses held back.
    do_reset();
    budget = 0;
    for (int i = 0; i < 8; i++) begin
      exp_cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h400 + 32'(8 * i), 7'd8, 32'h0));
      for (int b = 0; b < 8; b++) exp_rsp_q.push_back(mk_rsp(1, 32'h400 + 32'(8 * i + b)));
      drive(1, 1'b1, 1'b0, 32'h400 + 32'(8 * i), 7'd8, 32'h0);
      @(negedge clk);
      check("t4_rd_accept", 128'(s1_waitrequest), 128'(0));
      tick();
    end
    exp_cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h440, 7'd8, 32'h0));
    for (int b = 0; b < 8; b++) exp_rsp_q.push_back(mk_rsp(1, 32'h440 + 32'(b)));
    drive(1, 1'b1, 1'b0, 32'h440, 7'd8, 32'h0);
    @(negedge clk);
    check("t4_full_outstanding", 128'(outstanding), 128'(64));
    check("t4_full_s1_wait", 128'(s1_waitrequest), 128'(1));
    check("t4_full_m_read", 128'(m_read), 128'(0));
    tick();
    budget = 1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check("t4_one_back_outstanding", 128'(outstanding), 128'(63));
    check("t4_one_back_s1_wait", 128'(s1_waitrequest), 128'(1));
    tick();
    budget = 7;
    accepted = 1'b0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (!s1_waitrequest) accepted = 1'b1;
      else tick();
    end
    check("t4_ninth_accepted", 128'(accepted), 128'(1));
    check("t4_accept_outstanding", 128'(outstanding), 128'(56));
    tick();
    clear_inputs();
    budget = -1;
    wait_drain("t4");
    check("t4_err_clear", 128'(err), 128'(0));

    // Test 5: stray response with nothing outstanding.
    do_reset();
    tick();
    pend_data.push_back(32'hDEAD);
    pend_due.push_back(cyc);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (m_readdatavalid) seen = 1'b1;
    end
    check("t5_stray_seen", 128'(seen), 128'(1));
    check("t5_stray_rdv", 128'({s1_readdatavalid, s0_readdatavalid}), 128'(0));
    @(negedge clk);
    check("t5_err_set", 128'(err), 128'(1));
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    check("t5_err_sticky", 128'(err), 128'(1));
    tick();
    do_reset();
    @(negedge clk);
    check("t5_err_cleared", 128'(err), 128'(0));

    // Test 6: reset in the middle of a 4-beat write burst.
    tick();
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h50, 7'd1, 32'hC0));
    drive(0, 1'b0, 1'b1, 32'h50, 7'd1, 32'hC0);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 7'd0, 32'h0);
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h700, 7'd4, 32'hD0));
    drive(1, 1'b0, 1'b1, 32'h700, 7'd4, 32'hD0);
    tick();
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h700, 7'd4, 32'hD1));
    drive(1, 1'b0, 1'b1, 32'h700, 7'd4, 32'hD1);
    tick();
    reset = 1'b1;
    drive(1, 1'b0, 1'b1, 32'h700, 7'd4, 32'hD2);
    drive(0, 1'b0, 1'b1, 32'h600, 7'd1, 32'hE0);
    @(negedge clk);
    check("t6_rst_m_write", 128'(m_write), 128'(0));
    check("t6_rst_s0_wait", 128'(s0_waitrequest), 128'(1));
    check("t6_rst_s1_wait", 128'(s1_waitrequest), 128'(1));
    tick();
    tick();
    reset = 1'b0;
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h600, 7'd1, 32'hE0));
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 32'h710, 7'd1, 32'hE1));
    drive(1, 1'b0, 1'b1, 32'h710, 7'd1, 32'hE1);
    @(negedge clk);
    check("t6_post_s0_wait", 128'(s0_waitrequest), 128'(0));
    check("t6_post_s1_wait", 128'(s1_waitrequest), 128'(1));
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 7'd0, 32'h0);
    @(negedge clk);
    check("t6_s1_next_wait", 128'(s1_waitrequest), 128'(0));
    tick();
    clear_inputs();
    tick();

    // ---------------- final report ----------------
    check("end_cmd_queue_empty", 128'(exp_cmd_q.size()), 128'(0));
    check("end_rsp_queue_empty", 128'(exp_rsp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
